// File: rtl/rpi_bus_bank_arbiter.sv
// rpi_bus_bank_arbiter: shares one single-port synchronous RAM bank between
// the host side of the RPi bus peripheral and NUMBER_OF_REQUESTERS internal
// requesters. Host strobes always win the port. Internal requesters take the
// remaining cycles round-robin over a req/gnt handshake.
// Optional feature macro: RPI_BUS_BANK_ARBITER_STALL_COUNT_EN enables the
// saturating stall_count. Without it, stall_count is tied to zero.
module rpi_bus_bank_arbiter #(
  parameter int ADDRESS_WIDTH                = 16,
  parameter int DATA_WIDTH                   = 32,
  parameter int NUMBER_OF_REQUESTERS         = 4,
  parameter int LOG2_OF_NUMBER_OF_REQUESTERS = $clog2(NUMBER_OF_REQUESTERS),
  parameter int ERROR_COUNT_PICKOFF          = 7
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          host_write_strobe,
  input  logic                                          host_read_strobe,
  input  logic [ADDRESS_WIDTH-1:0]                      host_address,
  input  logic [DATA_WIDTH-1:0]                         host_write_data,
  output logic [DATA_WIDTH-1:0]                         host_read_data,
  output logic                                          host_read_valid,
  input  logic [NUMBER_OF_REQUESTERS-1:0]               req,
  input  logic [NUMBER_OF_REQUESTERS-1:0]               req_write,
  input  logic [NUMBER_OF_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0]    req_write_data,
  output logic [NUMBER_OF_REQUESTERS-1:0]               gnt,
  output logic [DATA_WIDTH-1:0]                         req_read_data,
  output logic [NUMBER_OF_REQUESTERS-1:0]               req_read_valid,
  output logic                                          mem_enable,
  output logic                                          mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0]                      mem_address,
  output logic [DATA_WIDTH-1:0]                         mem_write_data,
  input  logic [DATA_WIDTH-1:0]                         mem_read_data,
  output logic [ERROR_COUNT_PICKOFF:0]                  host_conflict_errors,
  output logic [ERROR_COUNT_PICKOFF:0]                  stall_count
);

  localparam int N  = NUMBER_OF_REQUESTERS;
  localparam int LW = LOG2_OF_NUMBER_OF_REQUESTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = ERROR_COUNT_PICKOFF + 1;
  // vld_pipe[0] loads at the issue edge, vld_pipe[STAGES] is consumed when
  // the RAM output is captured two edges after issue.
  localparam int STAGES = 1;

  typedef struct packed {
    logic          host;
    logic [LW-1:0] idx;
  } tag_t;

  // Per-requester views of the packed address/data buses
  logic [N-1:0][AW-1:0] addr_arr;
  logic [N-1:0][DW-1:0] wdat_arr;
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr_arr[i] = req_address[i*AW +: AW];
    assign wdat_arr[i] = req_write_data[i*DW +: DW];
  end

  logic wr_q, rd_q;
  logic wr_edge, rd_edge;
  assign wr_edge = host_write_strobe & ~wr_q;
  assign rd_edge = host_read_strobe & ~rd_q;

  // A requester holding gnt this cycle sits out the next selection.
  logic [N-1:0]  elig;
  logic [LW-1:0] rr_last, rr_sel, rr_j;
  logic          rr_found;
  assign elig = req & ~gnt;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_j     = '0;
    for (int k = 1; k <= N; k++) begin
      rr_j = LW'((32'(rr_last) + 32'(k)) % 32'(N));
      if (!rr_found && elig[rr_j]) begin
        rr_found = 1'b1;
        rr_sel   = rr_j;
      end
    end
  end

  logic          acc_en, acc_we, rr_take, rd_issue, conflict;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [N-1:0]  acc_gnt;
  tag_t          tag_next;

  // Port owner for the next cycle: host write, host read, internal, idle
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_gnt   = '0;
    rr_take   = 1'b0;
    rd_issue  = 1'b0;
    conflict  = 1'b0;
    tag_next  = '0;
    if (wr_edge) begin
      acc_en    = 1'b1;
      acc_we    = 1'b1;
      acc_addr  = host_address;
      acc_wdata = host_write_data;
      conflict  = rd_edge;
    end else if (rd_edge) begin
      acc_en        = 1'b1;
      acc_addr      = host_address;
      rd_issue      = 1'b1;
      tag_next.host = 1'b1;
    end else if (rr_found) begin
      acc_en       = 1'b1;
      acc_we       = req_write[rr_sel];
      acc_addr     = addr_arr[rr_sel];
      acc_wdata    = wdat_arr[rr_sel];
      acc_gnt      = N'(1) << rr_sel;
      rr_take      = 1'b1;
      rd_issue     = ~req_write[rr_sel];
      tag_next.idx = rr_sel;
    end
  end

  logic [STAGES:0] vld_pipe;
  tag_t [STAGES:0] tag_pipe;

  // Register the access, track read tags, capture RAM data two edges later
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q                 <= 1'b0;
      rd_q                 <= 1'b0;
      rr_last              <= LW'(N - 1);
      mem_enable           <= 1'b0;
      mem_write_enable     <= 1'b0;
      mem_address          <= '0;
      mem_write_data       <= '0;
      gnt                  <= '0;
      vld_pipe             <= '0;
      tag_pipe             <= '0;
      host_read_data       <= '0;
      host_read_valid      <= 1'b0;
      req_read_data        <= '0;
      req_read_valid       <= '0;
      host_conflict_errors <= '0;
    end else begin
      wr_q             <= host_write_strobe;
      rd_q             <= host_read_strobe;
      mem_enable       <= acc_en;
      mem_write_enable <= acc_we;
      mem_address      <= acc_addr;
      mem_write_data   <= acc_wdata;
      gnt              <= acc_gnt;
      if (rr_take) rr_last <= rr_sel;
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      tag_pipe <= {tag_pipe[STAGES-1:0], tag_next};
      host_read_valid <= 1'b0;
      req_read_valid  <= '0;
      if (vld_pipe[STAGES]) begin
        if (tag_pipe[STAGES].host) begin
          host_read_data  <= mem_read_data;
          host_read_valid <= 1'b1;
        end else begin
          req_read_data  <= mem_read_data;
          req_read_valid <= N'(1) << tag_pipe[STAGES].idx;
        end
      end
      if (conflict && host_conflict_errors != '1)
        host_conflict_errors <= host_conflict_errors + 1'b1;
    end
  end

`ifdef RPI_BUS_BANK_ARBITER_STALL_COUNT_EN
  logic [CW-1:0] stall_cnt;

  // Count edges where someone wants the port but no internal grant goes out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (|req && !rr_take && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule
